// File: rtl/ddr2_resp_pkg.sv
// Shared types and constants for the DDR2 device-side responder.
package ddr2_resp_pkg;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR,
    CMD_PRE, CMD_REF, CMD_MRS, CMD_RSV
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_WAIT, S_WR_BURST,
    S_RD_WAIT, S_RD_BURST
  } state_e;

  localparam int MRS_CL_LSB   = 4;
  localparam int MRS_BL_LSB   = 0;
  localparam int PRE_ALL_BIT  = 10;
  localparam logic [2:0] CL_MIN   = 3'd3;
  localparam logic [2:0] CL_MAX   = 3'd6;
  localparam logic [2:0] BL4_CODE = 3'd2;
  localparam logic [2:0] BL8_CODE = 3'd3;

  function automatic cmd_e decode(
    input logic ras_n,
    input logic cas_n,
    input logic we_n
  );
    cmd_e c;
    unique case ({ras_n, cas_n, we_n})
      3'b111: c = CMD_NOP;
      3'b011: c = CMD_ACT;
      3'b101: c = CMD_RD;
      3'b100: c = CMD_WR;
      3'b010: c = CMD_PRE;
      3'b001: c = CMD_REF;
      3'b000: c = CMD_MRS;
      default: c = CMD_RSV;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ddr2_resp_mem.sv
// Byte-lane-masked single-port array; synchronous write, combinational read.
module ddr2_resp_mem #(
  parameter int AW = 13,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [DW/8-1:0] dm,
  output logic [DW-1:0] rdata
);
  localparam int NL = DW / 8;

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (we && !dm[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ddr2_mem_responder.sv
// DDR2 device responder: command decode, bank table, burst sequencer.
// Optional DDR2_RESP_AUTO_PRECHARGE_EN closes the bank after an addr[10] burst.
module ddr2_mem_responder
  import ddr2_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int BA_WIDTH   = 3,
  parameter int DQ_WIDTH   = 16,
  parameter int ROW_BITS   = 4,
  parameter int COL_BITS   = 6,
  parameter int DEFAULT_CL = 3,
  parameter int DEFAULT_BL = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] ddr2_addr,
  input  logic [BA_WIDTH-1:0]   ddr2_ba,
  input  logic                  ddr2_cs_n,
  input  logic                  ddr2_ras_n,
  input  logic                  ddr2_cas_n,
  input  logic                  ddr2_we_n,
  input  logic                  ddr2_cke,
  input  logic [DQ_WIDTH-1:0]   ddr2_dq_in,
  input  logic [DQ_WIDTH/8-1:0] ddr2_dm,
  output logic [DQ_WIDTH-1:0]   ddr2_dq_out,
  output logic                  ddr2_dq_oe,
  output logic                  ddr2_dqs_out,
  output logic [2**BA_WIDTH-1:0] bank_open,
  output logic [2:0]            cfg_cl,
  output logic                  err_sticky,
  input  logic                  err_clr
);
  localparam int NB = 2**BA_WIDTH;
  localparam int MW = BA_WIDTH + ROW_BITS + COL_BITS;

  cmd_e   cmd;
  state_e state, state_nx, start_nx;
  logic [2:0] cl, wcnt, beat, mrs_cl, mrs_bl;
  logic bl8, in_burst, last, busy, sel_open, rw_ok;
  logic start_rd, start_wr, err, ap_close, cl_ok, bl_ok;
  logic beat_wr, beat_rd, mem_we;
  logic [BA_WIDTH-1:0] b_ba;
  logic [ROW_BITS-1:0] b_row;
  logic [COL_BITS-1:0] b_col, col_k;
  logic [ROW_BITS-1:0] rows [NB];
  logic [MW-1:0] mem_addr;
  logic [DQ_WIDTH-1:0] rdata;
  logic unused;

  assign cmd = (!ddr2_cs_n && ddr2_cke)
    ? decode(ddr2_ras_n, ddr2_cas_n, ddr2_we_n) : CMD_NOP;

  assign in_burst = state inside {S_WR_BURST, S_RD_BURST};
  assign last     = in_burst && (beat == (bl8 ? 3'd7 : 3'd3));
  // A new burst may start on the edge that carries the last beat.
  assign busy     = (state != S_IDLE) && !last;
  assign sel_open = bank_open[ddr2_ba];
  assign rw_ok    = !busy && sel_open;
  assign start_rd = (cmd == CMD_RD) && rw_ok;
  assign start_wr = (cmd == CMD_WR) && rw_ok;

  assign mrs_cl = ddr2_addr[MRS_CL_LSB +: 3];
  assign mrs_bl = ddr2_addr[MRS_BL_LSB +: 3];
  assign cl_ok  = (mrs_cl >= CL_MIN) && (mrs_cl <= CL_MAX);
  assign bl_ok  = (mrs_bl == BL4_CODE) || (mrs_bl == BL8_CODE);
  assign cfg_cl = cl;
  assign unused = ^{ddr2_addr[ADDR_WIDTH-1:11], ddr2_addr[9:7]};

  always_comb begin
    err = 1'b0;
    unique case (cmd)
      CMD_ACT:        err = sel_open;
      CMD_RD, CMD_WR: err = !rw_ok;
      CMD_REF:        err = |bank_open;
      CMD_MRS:        err = busy || !cl_ok || !bl_ok;
      CMD_RSV:        err = 1'b1;
      default:        err = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    start_nx = start_rd ? S_RD_WAIT : start_wr ? S_WR_WAIT : S_IDLE;
    state_nx = state;
    unique case (state)
      S_IDLE:     state_nx = start_nx;
      S_WR_WAIT:  if (wcnt == 3'd1) state_nx = S_WR_BURST;
      S_RD_WAIT:  if (wcnt == 3'd1) state_nx = S_RD_BURST;
      S_WR_BURST,
      S_RD_BURST: if (last) state_nx = start_nx;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    beat_wr = (state == S_WR_BURST);
    beat_rd = (state == S_RD_BURST);
    mem_we  = beat_wr && !ARESET;
  end

  // Column walks sequentially and wraps inside the burst-aligned block.
  always_comb begin
    col_k = b_col;
    if (bl8) col_k[2:0] = b_col[2:0] + beat;
    else     col_k[1:0] = b_col[1:0] + beat[1:0];
  end

  assign mem_addr = {b_ba, b_row, col_k};

  always_ff @(posedge ACLK) begin
    if (start_rd || start_wr) begin
      wcnt  <= cl - 3'd2;
      beat  <= 3'd0;
      b_ba  <= ddr2_ba;
      b_row <= rows[ddr2_ba];
      b_col <= ddr2_addr[COL_BITS-1:0];
    end else begin
      if (state inside {S_WR_WAIT, S_RD_WAIT}) wcnt <= wcnt - 3'd1;
      if (in_burst) beat <= beat + 3'd1;
    end
  end

`ifdef DDR2_RESP_AUTO_PRECHARGE_EN
  logic b_ap;
  always_ff @(posedge ACLK) begin
    if (ARESET) b_ap <= 1'b0;
    else if (start_rd || start_wr) b_ap <= ddr2_addr[PRE_ALL_BIT];
  end
  assign ap_close = b_ap && last;
`else
  assign ap_close = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (cmd == CMD_ACT && !sel_open) rows[ddr2_ba] <= ddr2_addr[ROW_BITS-1:0];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bank_open <= '0;
    end else begin
      if (ap_close) bank_open[b_ba] <= 1'b0;
      if (cmd == CMD_ACT && !sel_open) bank_open[ddr2_ba] <= 1'b1;
      if (cmd == CMD_PRE) begin
        if (ddr2_addr[PRE_ALL_BIT]) bank_open <= '0;
        else bank_open[ddr2_ba] <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cl  <= 3'(DEFAULT_CL);
      bl8 <= (DEFAULT_BL == 8);
    end else if (cmd == CMD_MRS && !busy) begin
      if (cl_ok) cl  <= mrs_cl;
      if (bl_ok) bl8 <= (mrs_bl == BL8_CODE);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET)       err_sticky <= 1'b0;
    else if (err)     err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ddr2_dq_out  <= '0;
      ddr2_dq_oe   <= 1'b0;
      ddr2_dqs_out <= 1'b0;
    end else begin
      ddr2_dq_out  <= beat_rd ? rdata : '0;
      ddr2_dq_oe   <= beat_rd;
      ddr2_dqs_out <= beat_rd && !beat[0];
    end
  end

  ddr2_resp_mem #(
    .AW(MW),
    .DW(DQ_WIDTH)
  ) u_mem (
    .clk  (ACLK),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(ddr2_dq_in),
    .dm   (ddr2_dm),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ddr2_mem_responder.sv
// Scoreboard bench for ddr2_mem_responder: write/read bursts, wrap,
// byte masks, protocol errors, MRS reprogramming and mid-burst reset.
module tb_ddr2_mem_responder;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_RSV = 3'b110;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        dqs;
  } exp_t;

  logic        clk = 1'b0;
  logic        ARESET;
  logic [27:0] addr;
  logic [2:0]  ba;
  logic        cs_n, ras_n, cas_n, we_n, cke;
  logic [15:0] dq_in;
  logic [1:0]  dm;
  logic [15:0] dq_out;
  logic        dq_oe, dqs_out;
  logic [7:0]  bank_open;
  logic [2:0]  cfg_cl;
  logic        err_sticky, err_clr;

  int n_vec = 0;
  int n_err = 0;
  int ncnt  = 0;
  bit mon_en = 1'b0;
  int cl = 3;
  int bl = 4;
  exp_t sb[$];
  logic [15:0] mdl [int];
  int mrow [8];
  logic [15:0] wd [8];

  always #5 clk = ~clk;

  ddr2_mem_responder dut (
    .ACLK        (clk),
    .ARESET      (ARESET),
    .ddr2_addr   (addr),
    .ddr2_ba     (ba),
    .ddr2_cs_n   (cs_n),
    .ddr2_ras_n  (ras_n),
    .ddr2_cas_n  (cas_n),
    .ddr2_we_n   (we_n),
    .ddr2_cke    (cke),
    .ddr2_dq_in  (dq_in),
    .ddr2_dm     (dm),
    .ddr2_dq_out (dq_out),
    .ddr2_dq_oe  (dq_oe),
    .ddr2_dqs_out(dqs_out),
    .bank_open   (bank_open),
    .cfg_cl      (cfg_cl),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx(int b, int r, int c, int k, int l);
    int ck;
    ck = (c & ~(l - 1)) | ((c + k) & (l - 1));
    return (b << 10) | (r << 6) | ck;
  endfunction

  // Output registered at posedge is sampled at the following negedge.
  always @(negedge clk) begin
    ncnt <= ncnt + 1;
    if (mon_en) begin
      if (dq_oe === 1'b1) begin
        if (sb.size() == 0) begin
          check("oe_unexp", 1, 0);
        end else begin
          check("rd_cyc", ncnt + 1, sb[0].cyc);
          check("rd_data", {16'h0, dq_out}, {16'h0, sb[0].data});
          check("rd_dqs", {31'h0, dqs_out}, {31'h0, sb[0].dqs});
          sb.delete(0);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= ncnt + 1) begin
        check("rd_miss", 0, 1);
        sb.delete(0);
      end else begin
        check("idle_out", {30'h0, dq_oe, dqs_out}, 0);
      end
    end
  end

  task automatic slot(input logic [2:0] c, input logic [2:0] b,
                      input logic [27:0] a, input logic [15:0] d,
                      input logic [1:0] m);
    @(negedge clk);
    #1;
    {ras_n, cas_n, we_n} = c;
    ba      = b;
    addr    = a;
    dq_in   = d;
    dm      = m;
    err_clr = 1'b0;
  endtask

  task automatic nop(input int n);
    repeat (n) slot(C_NOP, 3'd0, 28'd0, 16'd0, 2'b00);
  endtask

  task automatic wr(input int b, input int col, input logic [1:0] m0);
    logic [1:0]  m;
    logic [15:0] old;
    int i;
    slot(C_WR, 3'(b), 28'(col), 16'd0, 2'b00);
    repeat (cl - 2) nop(1);
    for (int k = 0; k < bl; k++) begin
      m = (k == 0) ? m0 : 2'b00;
      slot(C_NOP, 3'd0, 28'd0, wd[k], m);
      i = idx(b, mrow[b], col, k, bl);
      old = mdl.exists(i) ? mdl[i] : 16'h0;
      mdl[i] = {m[1] ? old[15:8] : wd[k][15:8],
                m[0] ? old[7:0]  : wd[k][7:0]};
    end
  endtask

  task automatic rd(input int b, input int col);
    int i;
    slot(C_RD, 3'(b), 28'(col), 16'd0, 2'b00);
    for (int k = 0; k < bl; k++) begin
      i = idx(b, mrow[b], col, k, bl);
      sb.push_back('{ncnt + cl + k, mdl[i], ~k[0]});
    end
  endtask

  initial begin
    ARESET = 1'b1;
    cs_n = 1'b0;
    cke = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
    ba = 3'd0;
    addr = 28'd0;
    dq_in = 16'd0;
    dm = 2'b00;
    err_clr = 1'b0;
    nop(3);
    ARESET = 1'b0;
    nop(1);
    check("rst_bank", {24'h0, bank_open}, 0);
    check("rst_cl", {29'h0, cfg_cl}, 3);
    check("rst_err", {31'h0, err_sticky}, 0);
    check("rst_oe", {31'h0, dq_oe}, 0);
    check("rst_dq", {16'h0, dq_out}, 0);
    check("rst_dqs", {31'h0, dqs_out}, 0);
    mon_en = 1'b1;

    slot(C_MRS, 3'd0, 28'h032, 16'd0, 2'b00);
    nop(1);
    check("mrs_cl3", {29'h0, cfg_cl}, 3);
    slot(C_ACT, 3'd1, 28'd5, 16'd0, 2'b00);
    mrow[1] = 5;
    nop(1);
    check("act_open", {24'h0, bank_open}, 32'h02);

    wd = '{16'hBEEF, 16'hDEAD, 16'h1234, 16'h5678, 0, 0, 0, 0};
    wr(1, 0, 2'b00);
    nop(2);
    rd(1, 0);
    nop(cl + bl + 1);
    rd(1, 2);
    nop(cl + bl + 1);
    check("no_err", {31'h0, err_sticky}, 0);

    wd = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0};
    wr(1, 0, 2'b01);
    nop(2);
    rd(1, 0);
    nop(cl + bl + 1);

    slot(C_RD, 3'd3, 28'd0, 16'd0, 2'b00);
    nop(1);
    check("err_rd_closed", {31'h0, err_sticky}, 1);
    slot(C_ACT, 3'd1, 28'd7, 16'd0, 2'b00);
    slot(C_REF, 3'd0, 28'd0, 16'd0, 2'b00);
    slot(C_MRS, 3'd0, 28'h072, 16'd0, 2'b00);
    nop(1);
    check("err_cl_kept", {29'h0, cfg_cl}, 3);
    check("err_bank_kept", {24'h0, bank_open}, 32'h02);
    check("err_held", {31'h0, err_sticky}, 1);
    nop(6);
    err_clr = 1'b1;
    nop(1);
    check("err_clr", {31'h0, err_sticky}, 0);
    slot(C_RSV, 3'd0, 28'd0, 16'd0, 2'b00);
    err_clr = 1'b1;
    nop(1);
    check("err_clr_vs_new", {31'h0, err_sticky}, 1);
    err_clr = 1'b1;
    nop(1);
    check("err_clr2", {31'h0, err_sticky}, 0);

    slot(C_ACT, 3'd0, 28'd3, 16'd0, 2'b00);
    cke = 1'b0;
    nop(1);
    cke = 1'b1;
    check("cke_ignored", {24'h0, bank_open}, 32'h02);

    slot(C_MRS, 3'd0, 28'h053, 16'd0, 2'b00);
    cl = 5;
    bl = 8;
    nop(1);
    check("mrs_cl5", {29'h0, cfg_cl}, 5);
    wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
           16'h5555, 16'h6666, 16'h7777, 16'h8888};
    wr(1, 8, 2'b00);
    nop(2);
    rd(1, 8);
    nop(cl + bl + 1);
    rd(1, 13);
    nop(cl + bl + 1);
    check("bl8_no_err", {31'h0, err_sticky}, 0);

    slot(C_PRE, 3'd2, 28'd0, 16'd0, 2'b00);
    nop(1);
    check("pre_closed_ok", {31'h0, err_sticky}, 0);
    check("pre_one", {24'h0, bank_open}, 32'h02);
    slot(C_PRE, 3'd0, 28'h400, 16'd0, 2'b00);
    nop(1);
    check("pre_all", {24'h0, bank_open}, 0);

    slot(C_ACT, 3'd1, 28'd5, 16'd0, 2'b00);
    nop(1);
    rd(1, 0);
    nop(5);
    ARESET = 1'b1;
    while (sb.size() != 0 && sb[$].cyc > ncnt) sb.pop_back();
    nop(1);
    ARESET = 1'b0;
    cl = 3;
    bl = 4;
    check("mid_rst_oe", {31'h0, dq_oe}, 0);
    check("mid_rst_bank", {24'h0, bank_open}, 0);
    check("mid_rst_cl", {29'h0, cfg_cl}, 3);
    nop(12);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
